add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter SETTLE, default 4, meaning cycles the 8-bit adder/subtractor inputs are held stable before its result is sampled (legal 1..15).
REQ-002 Parameter DEPTH, default 4, meaning operand FIFO entries (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand word offered.
REQ-006 in_ready  output  1  FIFO can accept a word this cycle.
REQ-007 in_mode  input  1  1 = add (a+b), 0 = subtract (a-b).
REQ-008 in_a, in_b  input  8 each  unsigned/two's-complement operands.
REQ-009 add_a, add_b  output  8 each  registered operands driven to the adder.
REQ-010 add_mode  output  1  registered mode driven to the adder.
REQ-011 add_sum  input  8  adder sum return.
REQ-012 add_cout  input  1  adder carry-out return.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_sum  output  8, out_cout  output  1, out_mode  output  1, out_ovf  output  1  captured result, carry, mode, signed overflow.
REQ-016 busy  output  1  FSM not IDLE or FIFO non-empty.
REQ-017 done_cnt  output  16  results accepted downstream since reset.

Function
REQ-018 Input word {mode,a,b} SHALL be pushed into the FIFO on any edge with in_valid && in_ready.
REQ-019 in_ready SHALL equal !full from registered FIFO count; a pop in the same cycle does not raise in_ready that cycle.
REQ-020 FSM states SHALL be IDLE, DRIVE, HOLD.
REQ-021 IDLE: if FIFO non-empty, pop head, load add_a/add_b/add_mode, load settle counter with SETTLE-1, go DRIVE; else stay.
REQ-022 DRIVE: add_* SHALL stay constant; decrement counter each cycle; on edge where counter==0, capture add_sum/add_cout into out_sum/out_cout, compute out_ovf, go HOLD.
REQ-023 HOLD: out_valid=1 and all out_* stable; on out_valid && out_ready go IDLE and increment done_cnt.
REQ-024 Latency: word pushed into empty FIFO with FSM in IDLE at edge E SHALL produce out_valid=1 after edge E+1+SETTLE; one IDLE bubble between consecutive results.
REQ-025 out_ovf, add mode: (a[7]==b[7]) && (sum[7]!=a[7]); subtract mode: (a[7]!=b[7]) && (sum[7]!=a[7]), using the held add_a/add_b.
REQ-026 out_cout SHALL pass add_cout unmodified (subtract: 1 = no borrow).
REQ-027 Capacity SHALL be DEPTH queued words plus one in DRIVE/HOLD; the next word stalls with in_ready=0.
REQ-028 Push into a non-full FIFO while the FSM pops in the same edge SHALL keep count unchanged; pointers wrap modulo DEPTH.
REQ-029 done_cnt SHALL wrap 0xFFFF -> 0x0000.
REQ-030 out_valid SHALL never drop without acceptance.

Reset
REQ-031 rst SHALL, on the next edge, empty the FIFO and clear pointers/count, force IDLE, and zero add_a, add_b, add_mode, out_sum, out_cout, out_mode, out_ovf, out_valid, done_cnt; in_ready=1 and busy=0 after reset.
REQ-032 rst asserted during DRIVE or HOLD SHALL discard the in-flight and queued words; no result is emitted for them.

Structure
REQ-033 Package add_seq_pkg SHALL hold the state enum, the {mode,a,b} 17-bit word type, and DEPTH/SETTLE defaults.
REQ-034 FIFO SHALL be a separate sub-module add_seq_fifo (synchronous push/pop, full/empty, count); overflow logic and FSM stay in add_seq_ctrl.

Verification (bench uses a behavioural adder model on add_* -> add_sum/add_cout)
REQ-035 mode=1, a=100, b=27, out_ready=1 -> out_sum=127, out_cout=0, out_ovf=0, out_valid after SETTLE+1 edges from push.
REQ-036 mode=1, a=100, b=28 -> out_sum=128, out_ovf=1, out_cout=0; mode=0, a=0x80, b=1 -> out_sum=0x7F, out_ovf=1, out_cout=1.
REQ-037 mode=0, a=5, b=10 -> out_sum=251, out_cout=0, out_ovf=0.
REQ-038 out_ready=0, push 6 words back-to-back -> first 5 accepted, in_ready=0 on 6th; release out_ready -> 5 results in push order, done_cnt=5.
REQ-039 Assert rst in DRIVE with 3 words queued -> next edge out_valid=0, in_ready=1, busy=0, done_cnt=0; no stale result afterwards.
REQ-040 Hold out_ready=0 for 10 cycles in HOLD -> out_* unchanged, add_* unchanged, no pop from FIFO.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and default parameters for the add/subtract sequencing controller.
package add_seq_pkg;

    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned SETTLE_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_HOLD
    } state_t;

    // One queued operation: mode (1 = add, 0 = subtract) and both operands.
    typedef struct packed {
        logic       mode;
        logic [7:0] a;
        logic [7:0] b;
    } word_t;

endpackage

// File: rtl/add_seq_fifo.sv
// Synchronous operand FIFO with registered occupancy count; push is ignored
// when full and pop is ignored when empty.
module add_seq_fifo
    import add_seq_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  word_t         push_data,
    input  logic          pop,
    output word_t         pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    word_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequences queued operand words through an external 8-bit adder/subtractor,
// holding its inputs for SETTLE cycles before sampling the result.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_mode,
    input  logic [7:0]  add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_sum,
    output logic        out_cout,
    output logic        out_mode,
    output logic        out_ovf,
    output logic        busy,
    output logic [15:0] done_cnt
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_t        state;
    state_t        state_nxt;
    word_t         fifo_head;
    word_t         in_word;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_pop;
    logic          load;
    logic          capture;
    logic          accept;
    logic [3:0]    settle_cnt;
    logic          ovf_now;

    assign in_word  = '{mode: in_mode, a: in_a, b: in_b};
    assign in_ready = !fifo_full;

    add_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data (in_word),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load      = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign out_valid = (state == ST_HOLD);
    assign accept    = out_valid && out_ready;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    // Signed overflow from the held operands: add overflows when the operand
    // signs agree, subtract when they differ, and the result sign leaves a's.
    assign ovf_now = (add_mode ? (add_a[7] == add_b[7]) : (add_a[7] != add_b[7]))
                     && (add_sum[7] != add_a[7]);

    always_ff @(posedge clk) begin
        if (rst) begin
            add_a      <= '0;
            add_b      <= '0;
            add_mode   <= 1'b0;
            settle_cnt <= '0;
            out_sum    <= '0;
            out_cout   <= 1'b0;
            out_mode   <= 1'b0;
            out_ovf    <= 1'b0;
            done_cnt   <= '0;
        end else begin
            if (load) begin
                add_a      <= fifo_head.a;
                add_b      <= fifo_head.b;
                add_mode   <= fifo_head.mode;
                settle_cnt <= 4'(SETTLE - 1);
            end else if (state == ST_DRIVE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (capture) begin
                out_sum  <= add_sum;
                out_cout <= add_cout;
                out_mode <= add_mode;
                out_ovf  <= ovf_now;
            end
            if (accept) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl: a behavioural adder closes the loop and
// expected results are queued at push time and retired on each accepted output.
module tb_add_seq_ctrl;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_mode;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sum;
    logic        out_cout;
    logic        out_mode;
    logic        out_ovf;
    logic        busy;
    logic [15:0] done_cnt;

    add_seq_ctrl #(
        .SETTLE (SETTLE),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_mode  (add_mode),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_mode  (out_mode),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural adder/subtractor; subtract is a + ~b + 1 so carry means no borrow.
    always_comb begin
        if (add_mode) {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};
        else          {add_cout, add_sum} = {1'b0, add_a} + {1'b0, ~add_b} + 9'd1;
    end

    typedef struct {
        logic       mode;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned push_cyc = 0;
    int unsigned n_pushed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic m, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   r;
        if (m) begin
            e.sum  = a + b;
            e.cout = (int'(a) + int'(b)) > 255;
            r      = int'($signed(a)) + int'($signed(b));
        end else begin
            e.sum  = a - b;
            e.cout = (a >= b);
            r      = int'($signed(a)) - int'($signed(b));
        end
        e.mode = m;
        e.ovf  = (r > 127) || (r < -128);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("stale_result", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out_sum",  32'(out_sum),  32'(mon_e.sum));
                check("out_cout", 32'(out_cout), 32'(mon_e.cout));
                check("out_ovf",  32'(out_ovf),  32'(mon_e.ovf));
                check("out_mode", 32'(out_mode), 32'(mon_e.mode));
            end
        end
    end

    task automatic push_word(input logic m, input logic [7:0] a, input logic [7:0] b);
        int unsigned t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("push_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(model(m, a, b));
            n_pushed++;
            @(posedge clk);
            #1;
            push_cyc = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int unsigned t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        @(negedge clk);
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("drain_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        n_pushed = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0]  dir_a [4] = '{8'd100, 8'd100, 8'h80, 8'd5};
    logic [7:0]  dir_b [4] = '{8'd27,  8'd28,  8'd1,  8'd10};
    logic        dir_m [4] = '{1'b1,   1'b1,   1'b0,  1'b0};
    logic [11:0] snap_out;
    logic [16:0] snap_add;
    int unsigned t0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done_cnt",  32'(done_cnt),  32'd0);
        check("rst_add",       32'({add_a, add_b, add_mode}), 32'd0);
        check("rst_out",       32'({out_sum, out_cout, out_mode, out_ovf}), 32'd0);
        rst = 1'b0;

        // Directed vectors including signed-overflow and borrow corners.
        for (int i = 0; i < 4; i++) begin
            push_word(dir_m[i], dir_a[i], dir_b[i]);
            wait_valid();
            check("latency", 32'(cyc - push_cyc), 32'(SETTLE + 1));
            wait_idle();
        end
        check("done_directed", 32'(done_cnt), 32'd4);

        // Two queued words: one IDLE bubble between results.
        push_word(1'b1, 8'd3, 8'd4);
        push_word(1'b0, 8'd9, 8'd2);
        wait_valid();
        t0 = cyc;
        @(negedge clk);
        wait_valid();
        check("result_gap", 32'(cyc - t0), 32'(SETTLE + 2));
        wait_idle();

        // Capacity: DEPTH queued plus one in flight, then stall.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b1; in_a = 8'hAA; in_b = 8'h55;
        for (int i = 0; i < 8; i++) begin
            check("full_stall", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Results must freeze while downstream stalls.
        wait_valid();
        snap_out = {out_sum, out_cout, out_ovf, out_mode, out_valid};
        snap_add = {add_a, add_b, add_mode};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out", 32'({out_sum, out_cout, out_ovf, out_mode, out_valid}), 32'(snap_out));
            check("hold_add", 32'({add_a, add_b, add_mode}), 32'(snap_add));
            check("hold_nopop", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();
        check("done_capacity", 32'(done_cnt), 32'd5);
        check("sb_drained_cap", 32'(sb.size()), 32'd0);

        // Reset while the first word settles and three more are queued.
        do_reset();
        for (int i = 0; i < 4; i++) push_word(1'b1, 8'(i + 1), 8'd7);
        @(negedge clk);
        check("pre_rst_busy",  32'(busy),      32'd1);
        check("pre_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        sb.delete();
        n_pushed = 0;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_done",  32'(done_cnt),  32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_idle", 32'({busy, out_valid}), 32'd0);

        // Random traffic with random backpressure.
        do_reset();
        fork
            begin
                for (int i = 0; i < 24; i++)
                    push_word(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            end
            begin
                repeat (200) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();
        check("done_random", 32'(done_cnt), 32'(n_pushed));
        check("sb_drained_rand", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
